// File: rtl/pe_bus_responder_if.sv
// pe_bus_responder_if
//   Groups the PE-facing request/response signals and the data-memory port
//   of pe_bus_responder into one bundle.
//   master : the PE plus data-memory side (drives requests, memory returns)
//   slave  : the responder (drives operands, acks and memory requests)
interface pe_bus_responder_if;
  // PE register-file requests
  logic        reg_select;
  logic [4:0]  rs1In;
  logic [4:0]  rs2In;
  logic [4:0]  rdIn;
  logic        rdWrite;
  logic [31:0] result_in;
  // PE load/store requests
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  // Responses to the PE
  logic [31:0] AmuxOut;
  logic [31:0] BmuxOut;
  logic        data_Ready;
  logic        mem_ack;
  logic        mem_err;
  // Single-port data memory
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_valid;

  modport master (
    output reg_select, rs1In, rs2In, rdIn, rdWrite, result_in,
    output mem_read, mem_write, mem_address,
    output dmem_rdata, dmem_valid,
    input  AmuxOut, BmuxOut, data_Ready, mem_ack, mem_err,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata
  );

  modport slave (
    input  reg_select, rs1In, rs2In, rdIn, rdWrite, result_in,
    input  mem_read, mem_write, mem_address,
    input  dmem_rdata, dmem_valid,
    output AmuxOut, BmuxOut, data_Ready, mem_ack, mem_err,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/pe_bus_responder.sv
// pe_bus_responder
//   Serves one PE: holds the 32x32 register file (x0 hard-wired to zero),
//   answers operand reads on AmuxOut/BmuxOut, takes writebacks every cycle,
//   and forwards loads/stores to a single-port data memory with a
//   four-phase completion handshake and an optional wait timeout.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : pe_bus_responder_if.slave (PE requests/responses + dmem port)
// Parameters:
//   TIMEOUT  : data-memory wait limit in cycles, 0 disables the timeout
module pe_bus_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  pe_bus_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REG, MEM, DONE} state_t;

  localparam logic [31:0] TO_LAST = TIMEOUT - 1;

  state_t      state, state_nxt;
  logic [31:0] regs [32];

  logic [4:0]  rs1_q, rs2_q;
  logic        is_mem_q, we_q, err_q;
  logic [31:0] addr_q, wdata_q, cnt_q, a_q, b_q;

  logic        cap_reg, cap_mem, err_nxt, timeout_hit, done_exit;
  logic [31:0] cnt_nxt, a_nxt, b_nxt, rd_a, rd_b;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // The handshake closes on the same request line that opened it.
  assign done_exit = is_mem_q ? (we_q ? !bus.mem_write : !bus.mem_read)
                              : !bus.reg_select;

  // Same-cycle writeback to the latched index overrides the stored value.
  always_comb begin
    rd_a = (rs1_q == '0) ? '0 : regs[rs1_q];
    rd_b = (rs2_q == '0) ? '0 : regs[rs2_q];
    if (bus.rdWrite && (bus.rdIn == rs1_q) && (rs1_q != '0)) rd_a = bus.result_in;
    if (bus.rdWrite && (bus.rdIn == rs2_q) && (rs2_q != '0)) rd_b = bus.result_in;
  end

  // Register file: writes are independent of the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.rdWrite && (bus.rdIn != '0)) begin
      regs[bus.rdIn] <= bus.result_in;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.mem_write || bus.mem_read) state_nxt = MEM;
        else if (bus.reg_select)           state_nxt = REG;
      end
      REG:  state_nxt = DONE;
      MEM:  if (bus.dmem_valid || timeout_hit) state_nxt = DONE;
      DONE: if (done_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (next values of the held response registers)
  always_comb begin
    cap_reg = 1'b0;
    cap_mem = 1'b0;
    cnt_nxt = cnt_q;
    a_nxt   = a_q;
    b_nxt   = b_q;
    err_nxt = err_q;
    unique case (state)
      IDLE: begin
        if (bus.mem_write || bus.mem_read) begin
          cap_mem = 1'b1;
          cnt_nxt = '0;
          err_nxt = 1'b0;
        end else if (bus.reg_select) begin
          cap_reg = 1'b1;
        end
      end
      REG: begin
        a_nxt   = rd_a;
        b_nxt   = rd_b;
        err_nxt = 1'b0;
      end
      MEM: begin
        cnt_nxt = cnt_q + 32'd1;
        if (bus.dmem_valid) begin
          if (!we_q) a_nxt = bus.dmem_rdata;
          err_nxt = 1'b0;
        end else if (timeout_hit) begin
          a_nxt   = '0;
          err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      is_mem_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      if (cap_reg) begin
        rs1_q    <= bus.rs1In;
        rs2_q    <= bus.rs2In;
        is_mem_q <= 1'b0;
      end
      if (cap_mem) begin
        addr_q   <= bus.mem_address;
        wdata_q  <= bus.result_in;
        we_q     <= bus.mem_write;
        is_mem_q <= 1'b1;
      end
      cnt_q <= cnt_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      err_q <= err_nxt;
    end
  end

  // Flags and the memory request are decoded from state so reset drops them at once.
  assign bus.AmuxOut    = a_q;
  assign bus.BmuxOut    = b_q;
  assign bus.data_Ready = (state == DONE) && !is_mem_q;
  assign bus.mem_ack    = (state == DONE) && is_mem_q;
  assign bus.mem_err    = (state == DONE) && is_mem_q && err_q;
  assign bus.dmem_req   = (state == MEM);
  assign bus.dmem_we    = (state == MEM) && we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_pe_bus_responder.sv
module tb_pe_bus_responder;
  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total_cnt;

  pe_bus_responder_if bus ();

  pe_bus_responder #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (bus.AmuxOut !== 32'h0) $display("FAIL reset_a got=%h exp=%h", bus.AmuxOut, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.BmuxOut !== 32'h0) $display("FAIL reset_b got=%h exp=%h", bus.BmuxOut, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if ({bus.data_Ready, bus.mem_ack, bus.mem_err, bus.dmem_req, bus.dmem_we} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=%b",
               {bus.data_Ready, bus.mem_ack, bus.mem_err, bus.dmem_req, bus.dmem_we}, 5'b0);
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_writeback_read();
    bus.rdWrite = 1'b1; bus.rdIn = 5'd5; bus.result_in = 32'hDEADBEEF;
    tick();
    bus.rdIn = 5'd0; bus.result_in = 32'h1234;
    tick();
    bus.rdWrite = 1'b0;
    bus.reg_select = 1'b1; bus.rs1In = 5'd5; bus.rs2In = 5'd0;
    tick();
    total_cnt++;
    if (bus.data_Ready !== 1'b0) $display("FAIL rd_ready_early got=%b exp=0", bus.data_Ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.data_Ready !== 1'b1) $display("FAIL rd_ready got=%b exp=1", bus.data_Ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.AmuxOut !== 32'hDEADBEEF) $display("FAIL rd_a got=%h exp=%h", bus.AmuxOut, 32'hDEADBEEF);
    else pass_cnt++;
    total_cnt++;
    if (bus.BmuxOut !== 32'h0) $display("FAIL rd_b_x0 got=%h exp=%h", bus.BmuxOut, 32'h0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.data_Ready !== 1'b1) $display("FAIL rd_ready_hold got=%b exp=1", bus.data_Ready);
    else pass_cnt++;
    bus.reg_select = 1'b0;
    tick();
    total_cnt++;
    if (bus.data_Ready !== 1'b0) $display("FAIL rd_ready_clear got=%b exp=0", bus.data_Ready);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    bus.rdWrite = 1'b1; bus.rdIn = 5'd7; bus.result_in = 32'h11;
    tick();
    bus.rdWrite = 1'b0;
    bus.reg_select = 1'b1; bus.rs1In = 5'd7; bus.rs2In = 5'd5;
    tick();
    bus.rdWrite = 1'b1; bus.rdIn = 5'd7; bus.result_in = 32'h22;
    tick();
    bus.rdWrite = 1'b0;
    total_cnt++;
    if (bus.AmuxOut !== 32'h22) $display("FAIL bypass_a got=%h exp=%h", bus.AmuxOut, 32'h22);
    else pass_cnt++;
    total_cnt++;
    if (bus.BmuxOut !== 32'hDEADBEEF) $display("FAIL bypass_b got=%h exp=%h", bus.BmuxOut, 32'hDEADBEEF);
    else pass_cnt++;
    bus.reg_select = 1'b0;
    tick();
    bus.reg_select = 1'b1; bus.rs1In = 5'd7; bus.rs2In = 5'd7;
    tick();
    tick();
    total_cnt++;
    if ({bus.AmuxOut, bus.BmuxOut} !== {32'h22, 32'h22})
      $display("FAIL bypass_stored got=%h_%h exp=%h_%h", bus.AmuxOut, bus.BmuxOut, 32'h22, 32'h22);
    else pass_cnt++;
    bus.reg_select = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    bus.mem_write = 1'b1; bus.mem_address = 32'h100; bus.result_in = 32'hCAFEF00D;
    tick();
    bus.result_in = 32'h0;
    total_cnt++;
    if ({bus.dmem_req, bus.dmem_we} !== 2'b11)
      $display("FAIL st_req got=%b exp=%b", {bus.dmem_req, bus.dmem_we}, 2'b11);
    else pass_cnt++;
    total_cnt++;
    if ({bus.dmem_addr, bus.dmem_wdata} !== {32'h100, 32'hCAFEF00D})
      $display("FAIL st_addr_data got=%h_%h exp=%h_%h", bus.dmem_addr, bus.dmem_wdata, 32'h100, 32'hCAFEF00D);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({bus.mem_ack, bus.dmem_req, bus.dmem_wdata} !== {1'b0, 1'b1, 32'hCAFEF00D})
      $display("FAIL st_wait got=%b%b_%h exp=01_%h", bus.mem_ack, bus.dmem_req, bus.dmem_wdata, 32'hCAFEF00D);
    else pass_cnt++;
    bus.dmem_valid = 1'b1;
    tick();
    bus.dmem_valid = 1'b0;
    total_cnt++;
    if ({bus.mem_ack, bus.mem_err, bus.dmem_req} !== 3'b100)
      $display("FAIL st_ack got=%b exp=%b", {bus.mem_ack, bus.mem_err, bus.dmem_req}, 3'b100);
    else pass_cnt++;
    total_cnt++;
    if (bus.AmuxOut !== 32'h22) $display("FAIL st_a_kept got=%h exp=%h", bus.AmuxOut, 32'h22);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.mem_ack !== 1'b1) $display("FAIL st_ack_hold got=%b exp=1", bus.mem_ack);
    else pass_cnt++;
    bus.mem_write = 1'b0;
    tick();
    total_cnt++;
    if (bus.mem_ack !== 1'b0) $display("FAIL st_ack_clear got=%b exp=0", bus.mem_ack);
    else pass_cnt++;
    // load back
    bus.mem_read = 1'b1; bus.mem_address = 32'h100;
    tick();
    total_cnt++;
    if ({bus.dmem_req, bus.dmem_we} !== 2'b10)
      $display("FAIL ld_req got=%b exp=%b", {bus.dmem_req, bus.dmem_we}, 2'b10);
    else pass_cnt++;
    bus.dmem_valid = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
    tick();
    bus.dmem_valid = 1'b0; bus.dmem_rdata = 32'h0;
    total_cnt++;
    if ({bus.mem_ack, bus.mem_err, bus.AmuxOut} !== {2'b10, 32'hCAFEF00D})
      $display("FAIL ld_ack got=%b%b_%h exp=10_%h", bus.mem_ack, bus.mem_err, bus.AmuxOut, 32'hCAFEF00D);
    else pass_cnt++;
    bus.mem_read = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    bus.mem_read = 1'b1; bus.mem_address = 32'h40;
    bus.reg_select = 1'b1; bus.rs1In = 5'd5; bus.rs2In = 5'd7;
    tick();
    total_cnt++;
    if ({bus.dmem_req, bus.data_Ready} !== 2'b10)
      $display("FAIL sim_mem_first got=%b exp=%b", {bus.dmem_req, bus.data_Ready}, 2'b10);
    else pass_cnt++;
    bus.dmem_valid = 1'b1; bus.dmem_rdata = 32'h55;
    tick();
    bus.dmem_valid = 1'b0;
    total_cnt++;
    if ({bus.mem_ack, bus.data_Ready, bus.AmuxOut} !== {2'b10, 32'h55})
      $display("FAIL sim_mem_ack got=%b%b_%h exp=10_%h", bus.mem_ack, bus.data_Ready, bus.AmuxOut, 32'h55);
    else pass_cnt++;
    bus.mem_read = 1'b0;
    tick();
    total_cnt++;
    if ({bus.mem_ack, bus.data_Ready} !== 2'b00)
      $display("FAIL sim_idle got=%b exp=%b", {bus.mem_ack, bus.data_Ready}, 2'b00);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.data_Ready !== 1'b0) $display("FAIL sim_reg_pending got=%b exp=0", bus.data_Ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.data_Ready, bus.AmuxOut, bus.BmuxOut} !== {1'b1, 32'hDEADBEEF, 32'h22})
      $display("FAIL sim_reg got=%b_%h_%h exp=1_%h_%h", bus.data_Ready, bus.AmuxOut, bus.BmuxOut,
               32'hDEADBEEF, 32'h22);
    else pass_cnt++;
    bus.reg_select = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bus.mem_read = 1'b1; bus.mem_address = 32'h200;
    tick();
    total_cnt++;
    if (bus.dmem_req !== 1'b1) $display("FAIL to_req got=%b exp=1", bus.dmem_req);
    else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total_cnt++;
      if ({bus.mem_ack, bus.dmem_req} !== 2'b01)
        $display("FAIL to_wait_%0d got=%b exp=%b", i, {bus.mem_ack, bus.dmem_req}, 2'b01);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({bus.mem_ack, bus.mem_err, bus.dmem_req, bus.AmuxOut} !== {3'b110, 32'h0})
      $display("FAIL to_ack got=%b%b%b_%h exp=110_%h", bus.mem_ack, bus.mem_err, bus.dmem_req,
               bus.AmuxOut, 32'h0);
    else pass_cnt++;
    bus.mem_read = 1'b0;
    tick();
    total_cnt++;
    if ({bus.mem_ack, bus.mem_err} !== 2'b00)
      $display("FAIL to_clear got=%b exp=%b", {bus.mem_ack, bus.mem_err}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_valid_wins();
    bus.mem_read = 1'b1; bus.mem_address = 32'h300;
    tick();
    tick();
    tick();
    tick();
    bus.dmem_valid = 1'b1; bus.dmem_rdata = 32'h77;
    tick();
    bus.dmem_valid = 1'b0;
    total_cnt++;
    if ({bus.mem_ack, bus.mem_err, bus.AmuxOut} !== {2'b10, 32'h77})
      $display("FAIL vw_ack got=%b%b_%h exp=10_%h", bus.mem_ack, bus.mem_err, bus.AmuxOut, 32'h77);
    else pass_cnt++;
    bus.mem_read = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    bus.mem_read = 1'b1; bus.mem_address = 32'h400;
    tick();
    bus.mem_read = 1'b0;
    bus.dmem_valid = 1'b1; bus.dmem_rdata = 32'h99;
    tick();
    bus.dmem_valid = 1'b0;
    total_cnt++;
    if ({bus.mem_ack, bus.AmuxOut} !== {1'b1, 32'h99})
      $display("FAIL drop_ack got=%b_%h exp=1_%h", bus.mem_ack, bus.AmuxOut, 32'h99);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.mem_ack !== 1'b0) $display("FAIL drop_exit got=%b exp=0", bus.mem_ack);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.mem_read = 1'b1; bus.mem_address = 32'h500;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.dmem_req, bus.mem_ack, bus.data_Ready, bus.AmuxOut} !== {3'b000, 32'h0})
      $display("FAIL rstmid_outs got=%b%b%b_%h exp=000_%h", bus.dmem_req, bus.mem_ack,
               bus.data_Ready, bus.AmuxOut, 32'h0);
    else pass_cnt++;
    bus.mem_read = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    bus.reg_select = 1'b1; bus.rs1In = 5'd5; bus.rs2In = 5'd7;
    tick();
    tick();
    total_cnt++;
    if ({bus.data_Ready, bus.AmuxOut, bus.BmuxOut} !== {1'b1, 32'h0, 32'h0})
      $display("FAIL rstmid_regs got=%b_%h_%h exp=1_%h_%h", bus.data_Ready, bus.AmuxOut,
               bus.BmuxOut, 32'h0, 32'h0);
    else pass_cnt++;
    bus.reg_select = 1'b0;
    tick();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset_n = 1'b0;
    bus.reg_select = 1'b0;
    bus.rs1In = '0;
    bus.rs2In = '0;
    bus.rdIn = '0;
    bus.rdWrite = 1'b0;
    bus.result_in = '0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.dmem_rdata = '0;
    bus.dmem_valid = 1'b0;

    test_reset();
    test_writeback_read();
    test_bypass();
    test_store_load();
    test_simultaneous();
    test_timeout();
    test_valid_wins();
    test_drop();
    test_reset_mid();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
